// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier control slice.
// Holds the default operand width, the FSM state encoding and a width helper.
// No logic, so no latency and no backpressure.
package booth_pkg;

    // Default operand width; also the number of Booth iterations
    localparam int BOOTH_N = 16;

    // Controller states; IDLE is zero so a cleared state register is idle
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_M = 3'd1,
        LOAD_Q = 3'd2,
        EVAL   = 3'd3,
        SHIFT  = 3'd4,
        DONE   = 3'd5
    } booth_state_t;

    // Bits needed to hold an iteration count of 0..n
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/booth_step_counter.sv
// Iteration counter for the Booth controller: load N, count down, flag last step.
// Registered count; last is decoded combinationally from the current count.
// No backpressure; decrements saturate at zero so the count never wraps.
module booth_step_counter
    import booth_pkg::*;
#(
    parameter int N = BOOTH_N
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic last
);

    localparam int CW = count_width(N);

    logic [CW-1:0] count;

    // Load takes priority over decrement; a zero count is held, never wrapped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(N);
        end else if (dec && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    // The step being taken now is the final one when one remains
    always_comb begin
        last = (count == CW'(1));
    end

endmodule

// File: rtl/booth_controller.sv
// Control FSM for a radix-2 Booth multiplier; the datapath (A, Q, Q-1, M) lives outside.
// Fixed latency: start accepted at one edge, done pulses 2N+2 edges later (2N+3 cycles).
// No backpressure; start is only sampled in IDLE and ignored while busy or in DONE.
module booth_controller
    import booth_pkg::*;
#(
    parameter int N = BOOTH_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] mcand,
    input  logic [N-1:0] mplier,
    input  logic         q0,
    input  logic         qm1,
    output logic         ldA,
    output logic         clrA,
    output logic         sft,
    output logic         ldQ,
    output logic         clrQ,
    output logic         clrff,
    output logic         ldM,
    output logic         addsub,
    output logic [N-1:0] data_out,
    output logic         busy,
    output logic         done
);

    booth_state_t state;
    booth_state_t state_nxt;

    logic [N-1:0] mcand_q;
    logic [N-1:0] mplier_q;
    logic         accept;
    logic         step_dec;
    logic         step_last;

    assign accept   = (state == IDLE) && start;
    assign step_dec = (state == SHIFT);

    booth_step_counter #(
        .N (N)
    ) u_step_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .dec   (step_dec),
        .last  (step_last)
    );

    // Operands are frozen at acceptance so later input changes cannot disturb a run
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (accept) begin
            mcand_q  <= mcand;
            mplier_q <= mplier;
        end
    end

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: load M, load Q, then N evaluate/shift pairs, then a single DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? LOAD_M : IDLE;
            LOAD_M:  state_nxt = LOAD_Q;
            LOAD_Q:  state_nxt = EVAL;
            EVAL:    state_nxt = SHIFT;
            SHIFT:   state_nxt = step_last ? DONE : EVAL;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode; everything is forced low while reset is asserted
    always_comb begin
        ldA      = 1'b0;
        clrA     = 1'b0;
        sft      = 1'b0;
        ldQ      = 1'b0;
        clrQ     = 1'b0;
        clrff    = 1'b0;
        ldM      = 1'b0;
        addsub   = 1'b0;
        data_out = '0;
        busy     = 1'b0;
        done     = 1'b0;
        if (rst_n) begin
            busy = (state != IDLE);
            case (state)
                LOAD_M: begin
                    ldM      = 1'b1;
                    clrA     = 1'b1;
                    clrff    = 1'b1;
                    data_out = mcand_q;
                end
                LOAD_Q: begin
                    ldQ      = 1'b1;
                    data_out = mplier_q;
                end
                EVAL: begin
                    // 10: start of a run of ones -> subtract; 01: end of run -> add
                    case ({q0, qm1})
                        2'b10: begin
                            ldA    = 1'b1;
                            addsub = 1'b1;
                        end
                        2'b01: begin
                            ldA    = 1'b1;
                            addsub = 1'b0;
                        end
                        default: ldA = 1'b0;
                    endcase
                end
                SHIFT:   sft  = 1'b1;
                DONE:    done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_controller.sv
// Bench for booth_controller with a behavioural Booth datapath attached.
// Directed vectors with hand-computed products plus multi-cycle corner sequences.
// Invariants are monitored every cycle and reported as one comparison at the end.
module tb_booth_controller;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] mcand;
    logic [N-1:0] mplier;
    logic         q0;
    logic         qm1;
    logic         ldA, clrA, sft, ldQ, clrQ, clrff, ldM, addsub;
    logic [N-1:0] data_out;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    booth_controller #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mcand    (mcand),
        .mplier   (mplier),
        .q0       (q0),
        .qm1      (qm1),
        .ldA      (ldA),
        .clrA     (clrA),
        .sft      (sft),
        .ldQ      (ldQ),
        .clrQ     (clrQ),
        .clrff    (clrff),
        .ldM      (ldM),
        .addsub   (addsub),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    // Behavioural Booth datapath driven by the controller
    logic [N-1:0] A     = '0;
    logic [N-1:0] Q     = '0;
    logic [N-1:0] M     = '0;
    logic         qm1_r = 1'b0;

    assign q0  = Q[0];
    assign qm1 = qm1_r;

    always @(posedge clk) begin
        if (ldM)   M     <= data_out;
        if (clrA)  A     <= '0;
        if (clrff) qm1_r <= 1'b0;
        if (ldQ)   Q     <= data_out;
        if (ldA)   A     <= addsub ? (A - M) : (A + M);
        if (sft)   {A, Q, qm1_r} <= {A[N-1], A, Q};
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle invariant monitor
    int   inv_err   = 0;
    int   done_cnt  = 0;
    logic done_prev = 1'b0;

    always @(negedge clk) begin
        if (ldA && sft) inv_err++;
        if (!(ldM || ldQ) && (data_out != '0)) inv_err++;
        if (clrQ) inv_err++;
        if (done && done_prev) inv_err++;
        if (done) done_cnt++;
        done_prev = done;
    end

    // Drive one operation; lat = negedges from the start cycle to the done cycle
    task automatic run_op(input logic [N-1:0] mc, input logic [N-1:0] mp, input bit scramble,
                          output int lat, output logic [2*N-1:0] prod);
        @(negedge clk);
        mcand  = mc;
        mplier = mp;
        start  = 1'b1;
        lat    = 0;
        prod   = '0;
        @(negedge clk);
        lat   = 1;
        start = 1'b0;
        while (!done && lat < 200) begin
            if (scramble) begin
                mcand  = N'($urandom);
                mplier = N'($urandom);
                start  = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        prod  = {A, Q};
    endtask

    typedef struct {
        logic [N-1:0]   mc;
        logic [N-1:0]   mp;
        logic [2*N-1:0] prod;
    } vec_t;

    vec_t vecs [8];

    int               lat;
    logic [2*N-1:0]   prod;
    int               dn;
    int               d1;
    int               d2;
    logic [2*N-1:0]   p1;
    int               sft_seen;
    int               dc_before;

    initial begin
        vecs[0] = '{16'h0003, 16'hFFFB, 32'hFFFF_FFF1};
        vecs[1] = '{16'h0007, 16'h0006, 32'h0000_002A};
        vecs[2] = '{16'h0000, 16'h1234, 32'h0000_0000};
        vecs[3] = '{16'hFFF8, 16'h0009, 32'hFFFF_FFB8};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 32'h0000_0001};
        vecs[5] = '{16'h7FFF, 16'h7FFF, 32'h3FFF_0001};
        vecs[6] = '{16'h8001, 16'h0002, 32'hFFFF_0002};
        vecs[7] = '{16'h0009, 16'hFFF8, 32'hFFFF_FFB8};

        rst_n  = 1'b0;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;

        // Reset state, including while reset is held
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data_out", data_out, 0);
        check("rst_ctrl", {ldA, clrA, sft, ldQ, clrQ, clrff, ldM, addsub}, 0);
        start = 1'b1;
        @(negedge clk);
        check("rst_start_ignored", busy, 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 0);

        // Directed product vectors
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].mc, vecs[i].mp, 1'b0, lat, prod);
            check($sformatf("vec%0d_latency", i), lat, 35);
            check($sformatf("vec%0d_product", i), prod, vecs[i].prod);
            @(negedge clk);
            check($sformatf("vec%0d_idle", i), {busy, done}, 0);
        end

        // Operands and start wiggled while busy must not disturb the run
        run_op(16'h0064, 16'hFF9C, 1'b1, lat, prod);
        check("scramble_latency", lat, 35);
        check("scramble_product", prod, 32'hFFFF_D8F0);
        @(negedge clk);

        // start held high across the whole run and through DONE
        mcand  = 16'h0005;
        mplier = 16'h0003;
        start  = 1'b1;
        dn = 0; d1 = 0; d2 = 0; p1 = '0;
        for (int i = 1; i <= 75; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("held_loadm_ctrl", {ldM, clrA, clrff, ldQ}, 4'b1110);
                check("held_loadm_bus", data_out, 16'h0005);
                mcand = 16'h0999;
            end
            if (i == 2) begin
                check("held_loadq_ctrl", {ldQ, ldM}, 2'b10);
                check("held_loadq_bus", data_out, 16'h0003);
                check("held_loadq_busy", busy, 1);
            end
            if (done) begin
                dn++;
                if (dn == 1) begin
                    d1 = i;
                    p1 = {A, Q};
                end else begin
                    d2 = i;
                end
            end
            if (i == 36) check("held_idle_after_done", busy, 0);
            if (i == 37) begin
                check("held_restart_from_idle", {busy, ldM}, 2'b11);
                check("held_restart_bus", data_out, 16'h0999);
                start = 1'b0;
            end
        end
        check("held_done_count", dn, 2);
        check("held_first_done_cycle", d1, 35);
        check("held_second_done_cycle", d2, 71);
        check("held_product", p1, 32'h0000_000F);
        check("held_second_product", {A, Q}, 32'h0000_0000 + 16'h0999 * 3);
        @(negedge clk);

        // Reset pulse during the fifth SHIFT aborts the run
        @(negedge clk);
        mcand  = 16'h000B;
        mplier = 16'h000D;
        start  = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        sft_seen = 0;
        for (int i = 0; i < 40 && sft_seen < 5; i++) begin
            if (sft) sft_seen++;
            if (sft_seen < 5) @(negedge clk);
        end
        check("abort_reached_shift5", sft_seen, 5);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_outputs_in_reset", {busy, done, sft, ldA}, 0);
        rst_n = 1'b1;
        #1;
        check("abort_idle_after_reset", {busy, done, data_out}, 0);
        dc_before = done_cnt;
        repeat (40) @(negedge clk);
        check("abort_no_done", done_cnt - dc_before, 0);
        run_op(16'hFFF8, 16'h0009, 1'b0, lat, prod);
        check("abort_fresh_latency", lat, 35);
        check("abort_fresh_product", prod, 32'hFFFF_FFB8);
        repeat (2) @(negedge clk);

        check("invariants", inv_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_controller.md
BOOTH_CONTROLLER -- requirements
Module: booth_controller

Interface
REQ-001 SHALL have parameter N, default 16, meaning operand width in bits and iteration count.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request pulse/level, sampled only in IDLE.
REQ-005 SHALL have port mcand  input  N  multiplicand, captured on accepted start.
REQ-006 SHALL have port mplier  input  N  multiplier, captured on accepted start.
REQ-007 SHALL have port q0  input  1  datapath Q[0].
REQ-008 SHALL have port qm1  input  1  datapath Q(-1) flop.
REQ-009 SHALL have ports ldA, clrA, sft, ldQ, clrQ, clrff, ldM, addsub  output  1 each  datapath controls (addsub: 0 add, 1 sub).
REQ-010 SHALL have port data_out  output  N  shared load bus to datapath.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse; product valid on datapath A:Q.

Function
REQ-013 SHALL implement states IDLE, LOAD_M, LOAD_Q, EVAL, SHIFT, DONE in a registered FSM; outputs decoded combinationally from state (and q0/qm1 in EVAL).
REQ-014 IDLE: start=1 -> capture mcand/mplier into internal registers, load count=N, go LOAD_M; start=0 -> stay.
REQ-015 LOAD_M: assert ldM, clrA, clrff; data_out=captured mcand; go LOAD_Q.
REQ-016 LOAD_Q: assert ldQ; data_out=captured mplier; go EVAL.
REQ-017 EVAL: {q0,qm1}=10 -> ldA=1, addsub=1; 01 -> ldA=1, addsub=0; 00/11 -> ldA=0; always go SHIFT.
REQ-018 SHIFT: assert sft; decrement count; count==1 before decrement -> DONE, else EVAL.
REQ-019 DONE: done=1 for exactly one cycle; go IDLE; start in DONE ignored.
REQ-020 Latency fixed at 2N+3 cycles: start accepted at edge k, done high in cycle k+2N+3 regardless of operand values.
REQ-021 start while busy SHALL be ignored; captured operands unchanged until next accepted start.
REQ-022 data_out SHALL be 0 outside LOAD_M/LOAD_Q; clrQ SHALL be held 0; at most one of ldA/sft asserted per cycle.
REQ-023 count SHALL be $clog2(N+1) bits wide; no wrap (never decremented at 0).
REQ-024 Product SHALL remain on datapath A:Q from DONE until the next accepted start's LOAD_M edge.
REQ-025 Most-negative mcand (-2^(N-1)) is out of range; result undefined, no error flag.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, count=0, captured operands=0, from any state including mid-operation.
REQ-027 During and after reset all control outputs, data_out, busy, done SHALL be 0; datapath registers are not cleared by reset (cleared by next LOAD_M).

Structure
REQ-028 Shared package booth_pkg SHALL hold the state enumeration and the default width constant N.
REQ-029 Iteration counter SHALL be a sub-module booth_step_counter (load, decrement, last flag); FSM remains in booth_controller.

Verification
REQ-030 N=16, mcand=3, mplier=-5 (0xFFFB), start one cycle -> done exactly 35 cycles later, A:Q=0xFFFFFFF1.
REQ-031 mcand=7, mplier=6 -> A:Q=0x0000002A; mcand=0, mplier=0x1234 -> 0x00000000 with same 35-cycle latency.
REQ-032 start held high through whole operation and re-asserted in DONE -> exactly one done, IDLE entered, second op starts only from IDLE sampling.
REQ-033 rst_n low for one cycle during SHIFT of iteration 5 -> next cycle IDLE, busy=0, done never pulses; fresh start -8 x 9 -> 0xFFFFFFB8.
REQ-034 mcand/mplier changed while busy -> result reflects operands captured at acceptance (e.g. 100 x -100 -> 0xFFFFD8F0).
REQ-035 Assertion checks every cycle: ldA & sft never both 1; data_out==0 outside load states; done width exactly one cycle.
